store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffer entries (power of two, 2..16).
REQ-002 Parameter INVALID_ROB, default 6'b010000, tag value meaning "no ROB entry".
REQ-003 clock  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; low clears all state immediately.
REQ-005 in_valid  in  1  store RS issues a resolved store this cycle.
REQ-006 in_rob  in  6  ROB tag of the store.
REQ-007 in_data  in  32  store value (low byte/half used for SB/SH).
REQ-008 in_addr  in  32  effective byte address (base + offset, already added).
REQ-009 in_size  in  3  funct3 subtype: 000 SB, 001 SH, 010 SW.
REQ-010 in_ready  out  1  buffer can accept a store (count < DEPTH).
REQ-011 commit_valid  in  1  ROB retires a store this cycle.
REQ-012 commit_rob  in  6  ROB tag being retired.
REQ-013 flush  in  1  mispredict/exception: discard all uncommitted entries.
REQ-014 mem_req  out  1  data-memory write request.
REQ-015 mem_addr  out  32  word address {addr[31:2],2'b00}.
REQ-016 mem_wdata  out  32  lane-aligned write data.
REQ-017 mem_be  out  4  byte enables.
REQ-018 mem_ack  in  1  memory accepted the write this cycle.
REQ-019 count  out  5  occupied entries; empty out 1 high when count==0.

Function
REQ-020 Circular FIFO, head/tail pointers wrap modulo DEPTH; entry = {valid, committed, rob, addr, data, size}.
REQ-021 Enqueue at tail when in_valid && in_ready; in_valid while full is ignored and sets sticky overflow flag (cleared only by reset).
REQ-022 commit_valid marks committed the oldest valid uncommitted entry whose rob equals commit_rob; no match is ignored; commit_rob==INVALID_ROB never matches.
REQ-023 Drain FSM states IDLE, REQ: IDLE->REQ when head entry valid and committed; mem_req registered, asserts the cycle after entering REQ condition.
REQ-024 In REQ, mem_req, mem_addr, mem_wdata, mem_be held stable until mem_ack; on mem_ack head pops, FSM returns IDLE (one bubble cycle minimum per store).
REQ-025 Byte lanes: SB be=0001<<addr[1:0], wdata=byte replicated x4; SH be=addr[1]?1100:0011, wdata=half replicated x2, addr[0] ignored; SW be=1111, addr[1:0] ignored.
REQ-026 Any other in_size: be=0000, entry still drains and pops normally.
REQ-027 flush: tail <= head + number of committed entries; uncommitted entries invalidated; committed entries and an in-flight REQ unaffected.
REQ-028 Same-cycle ordering: commit applied before flush; flush beats enqueue (enqueue dropped); pop and enqueue both apply, count unchanged.
REQ-029 in_ready and count reflect registered state only (no combinational path from mem_ack).

Reset
REQ-030 reset low: all valid/committed cleared, head=tail=0, FSM IDLE, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, count=0, empty=1, in_ready=1, overflow=0, ld_hit=0.
REQ-031 reset asserted mid-REQ abandons the write; mem_req drops asynchronously.

Configuration
REQ-032 Macro STORE_FWD_EN compiles in load forwarding: inputs ld_addr[31:0]; outputs ld_hit, ld_stall, ld_data[31:0].
REQ-033 With STORE_FWD_EN: youngest valid entry with same word address: SW -> ld_hit=1, ld_data=its data; SB/SH -> ld_stall=1; no match -> both 0; combinational.
REQ-034 Without STORE_FWD_EN: those ports absent, no comparators built.

Structure
REQ-035 Shared package holds SB/SH/SW codes, INVALID_ROB, entry struct typedef, FSM state enum.
REQ-036 One sub-module store_lane_align: combinational size/addr/data -> be, wdata.

Verification
REQ-037 Enqueue SW rob=3 addr=0x104 data=0xDEADBEEF, commit 3, ack after 2 cycles -> mem_req held 2 cycles, mem_addr=0x104, be=1111, then empty=1.
REQ-038 SB addr=0x203 data=0x5A -> mem_be=1000, mem_wdata=0x5A5A5A5A, mem_addr=0x200.
REQ-039 Fill 4 entries -> in_ready=0, 5th in_valid ignored, overflow=1, count=4.
REQ-040 Enqueue rob 1,2,3; commit 1; flush -> count=1, only rob 1 drains.
REQ-041 Reset low while mem_req=1 -> mem_req=0 same cycle, count=0.
REQ-042 STORE_FWD_EN: pending SW addr=0x40 data=7, ld_addr=0x40 -> ld_hit=1, ld_data=7; pending SB addr=0x41 -> ld_stall=1.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: store size codes, the "no ROB
// entry" tag, the buffer entry layout and the drain FSM states.
package store_buffer_pkg;

    localparam logic [2:0] SIZE_SB = 3'b000;
    localparam logic [2:0] SIZE_SH = 3'b001;
    localparam logic [2:0] SIZE_SW = 3'b010;

    localparam logic [5:0] INVALID_ROB_TAG = 6'b010000;

    typedef struct packed {
        logic        valid;
        logic        committed;
        logic [5:0]  rob;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  size;
    } sb_entry_t;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_t;

    // Word-aligned form of a byte address (low two bits forced to zero).
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Store lane alignment: turns a store's size, low address bits and value into
// the byte enables and lane-replicated write data seen by the data memory.
module store_lane_align
    import store_buffer_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata
);

    // Byte stores hit one lane, halves hit the upper or lower pair, words hit all four.
    always_comb begin
        be    = 4'b0000;
        wdata = data;
        case (size)
            SIZE_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{data[7:0]}};
            end
            SIZE_SH: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{data[15:0]}};
            end
            SIZE_SW: begin
                be    = 4'b1111;
                wdata = data;
            end
            default: begin
                be    = 4'b0000;
                wdata = data;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of resolved stores that are committed in ROB
// order and drained to data memory one at a time.
// Optional load forwarding is compiled in with the macro STORE_FWD_EN.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int         DEPTH       = 4,
    parameter logic [5:0] INVALID_ROB = INVALID_ROB_TAG
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [5:0]  in_rob,
    input  logic [31:0] in_data,
    input  logic [31:0] in_addr,
    input  logic [2:0]  in_size,
    output logic        in_ready,
    input  logic        commit_valid,
    input  logic [5:0]  commit_rob,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
`ifdef STORE_FWD_EN
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic        ld_stall,
    output logic [31:0] ld_data,
`endif
    output logic        overflow,
    output logic [4:0]  count,
    output logic        empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sb_entry_t          entries [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    drain_state_t       state;
    drain_state_t       next_state;

    logic [DEPTH-1:0]   commit_mask;
    logic               commit_found;
    logic [4:0]         keep_count;
    logic               push;
    logic               pop;
    logic [3:0]         head_be;
    logic [31:0]        head_wdata;

    assign in_ready = (count < 5'(DEPTH));
    assign empty    = (count == 5'd0);
    assign mem_req  = (state == DRAIN_REQ);
    assign push     = in_valid && in_ready && !flush;
    assign pop      = (state == DRAIN_REQ) && mem_ack;

    store_lane_align u_align (
        .size    (entries[head].size),
        .addr_lo (entries[head].addr[1:0]),
        .data    (entries[head].data),
        .be      (head_be),
        .wdata   (head_wdata)
    );

    // Locate the oldest uncommitted entry matching the retiring tag and count what survives a flush.
    always_comb begin
        commit_mask  = '0;
        commit_found = 1'b0;
        keep_count   = 5'd0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] idx;
            idx = head + PTR_W'(i);
            if (!commit_found && commit_valid && (commit_rob != INVALID_ROB) &&
                entries[idx].valid && !entries[idx].committed &&
                (entries[idx].rob == commit_rob)) begin
                commit_mask[idx] = 1'b1;
                commit_found     = 1'b1;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            keep_count = keep_count + 5'(entries[i].valid && (entries[i].committed || commit_mask[i]));
        end
    end

    // Entry storage, pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head     <= '0;
            tail     <= '0;
            count    <= 5'd0;
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_mask[i]) begin
                    entries[i].committed <= 1'b1;
                end
                if (flush && !(entries[i].committed || commit_mask[i])) begin
                    entries[i].valid <= 1'b0;
                end
            end
            if (pop) begin
                entries[head].valid     <= 1'b0;
                entries[head].committed <= 1'b0;
            end
            if (push) begin
                entries[tail] <= '{valid: 1'b1, committed: 1'b0, rob: in_rob,
                                   addr: in_addr, data: in_data, size: in_size};
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (flush) begin
                tail  <= head + PTR_W'(keep_count);
                count <= keep_count - 5'(pop);
            end else begin
                if (push) begin
                    tail <= tail + PTR_W'(1);
                end
                count <= count + 5'(push) - 5'(pop);
            end
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= DRAIN_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Start a write once the head is committed; return to idle on acknowledge.
    always_comb begin
        next_state = state;
        case (state)
            DRAIN_IDLE: begin
                if (entries[head].valid && entries[head].committed) begin
                    next_state = DRAIN_REQ;
                end
            end
            DRAIN_REQ: begin
                if (mem_ack) begin
                    next_state = DRAIN_IDLE;
                end
            end
            default: next_state = DRAIN_IDLE;
        endcase
    end

    // Capture the head store's address, data and enables as the write starts; hold them until acknowledged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'd0;
        end else if ((state == DRAIN_IDLE) && (next_state == DRAIN_REQ)) begin
            mem_addr  <= word_addr(entries[head].addr);
            mem_wdata <= head_wdata;
            mem_be    <= head_be;
        end
    end

`ifdef STORE_FWD_EN
    // Youngest matching word wins; only full-word stores can supply data, partial ones stall the load.
    always_comb begin
        ld_hit   = 1'b0;
        ld_stall = 1'b0;
        ld_data  = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] fidx;
            fidx = head + PTR_W'(i);
            if (entries[fidx].valid && (word_addr(entries[fidx].addr) == word_addr(ld_addr))) begin
                if (entries[fidx].size == SIZE_SW) begin
                    ld_hit   = 1'b1;
                    ld_stall = 1'b0;
                    ld_data  = entries[fidx].data;
                end else begin
                    ld_hit   = 1'b0;
                    ld_stall = 1'b1;
                    ld_data  = 32'd0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed scenarios followed by randomized
// traffic, all checked against a queue-based reference model.
// Load forwarding checks are included when STORE_FWD_EN is defined.
module tb_store_buffer;

    localparam int         DEPTH = 4;
    localparam logic [5:0] INV   = 6'b010000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [5:0]  in_rob = '0;
    logic [31:0] in_data = '0;
    logic [31:0] in_addr = '0;
    logic [2:0]  in_size = '0;
    logic        in_ready;
    logic        commit_valid = 1'b0;
    logic [5:0]  commit_rob = '0;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic        overflow;
    logic [4:0]  count;
    logic        empty;
`ifdef STORE_FWD_EN
    logic [31:0] ld_addr = '0;
    logic        ld_hit;
    logic        ld_stall;
    logic [31:0] ld_data;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          committed;
        logic [5:0]  rob;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  size;
    } mentry_t;

    mentry_t q[$];
    bit      busy = 1'b0;
    bit      ovf  = 1'b0;

    always #5 clock = ~clock;

    store_buffer #(.DEPTH(DEPTH), .INVALID_ROB(INV)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_rob       (in_rob),
        .in_data      (in_data),
        .in_addr      (in_addr),
        .in_size      (in_size),
        .in_ready     (in_ready),
        .commit_valid (commit_valid),
        .commit_rob   (commit_rob),
        .flush        (flush),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
`ifdef STORE_FWD_EN
        .ld_addr      (ld_addr),
        .ld_hit       (ld_hit),
        .ld_stall     (ld_stall),
        .ld_data      (ld_data),
`endif
        .overflow     (overflow),
        .count        (count),
        .empty        (empty)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void expectedLane(input mentry_t e, output logic [3:0] be,
                                         output logic [31:0] wd, output bit wd_known);
        wd_known = 1'b1;
        case (e.size)
            3'b000: begin be = 4'b0001 << e.addr[1:0]; wd = {4{e.data[7:0]}}; end
            3'b001: begin be = e.addr[1] ? 4'b1100 : 4'b0011; wd = {2{e.data[15:0]}}; end
            3'b010: begin be = 4'b1111; wd = e.data; end
            default: begin be = 4'b0000; wd = 32'd0; wd_known = 1'b0; end
        endcase
    endfunction

    task automatic checkModel();
        logic [3:0]  be;
        logic [31:0] wd;
        bit          wd_known;
        checkOutput("count", 32'(count), 32'(q.size()));
        checkOutput("empty", 32'(empty), 32'(q.size() == 0));
        checkOutput("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        checkOutput("overflow", 32'(overflow), 32'(ovf));
        checkOutput("mem_req", 32'(mem_req), 32'(busy));
        if (busy && q.size() > 0) begin
            expectedLane(q[0], be, wd, wd_known);
            checkOutput("mem_addr", mem_addr, {q[0].addr[31:2], 2'b00});
            checkOutput("mem_be", 32'(mem_be), 32'(be));
            if (wd_known) begin
                checkOutput("mem_wdata", mem_wdata, wd);
            end
        end
`ifdef STORE_FWD_EN
        begin
            bit          hit;
            bit          stall;
            logic [31:0] d;
            hit = 1'b0; stall = 1'b0; d = 32'd0;
            foreach (q[i]) begin
                if (q[i].addr[31:2] == ld_addr[31:2]) begin
                    hit   = (q[i].size == 3'b010);
                    stall = (q[i].size != 3'b010);
                    d     = q[i].data;
                end
            end
            checkOutput("ld_hit", 32'(ld_hit), 32'(hit));
            checkOutput("ld_stall", 32'(ld_stall), 32'(stall));
            if (hit) begin
                checkOutput("ld_data", ld_data, d);
            end
        end
`endif
    endtask

    task automatic modelUpdate();
        int n;
        bit pop;
        bit nb;
        n   = q.size();
        pop = busy && mem_ack;
        nb  = busy ? !mem_ack : (n > 0 && q[0].committed);
        if (commit_valid && commit_rob != INV) begin
            for (int i = 0; i < q.size(); i++) begin
                if (!q[i].committed && q[i].rob == commit_rob) begin
                    q[i].committed = 1'b1;
                    break;
                end
            end
        end
        if (flush) begin
            mentry_t kept[$];
            foreach (q[i]) begin
                if (q[i].committed) kept.push_back(q[i]);
            end
            q = kept;
        end
        if (pop) void'(q.pop_front());
        if (in_valid) begin
            if (n >= DEPTH) begin
                ovf = 1'b1;
            end else if (!flush) begin
                mentry_t e;
                e.committed = 1'b0; e.rob = in_rob; e.addr = in_addr;
                e.data = in_data; e.size = in_size;
                q.push_back(e);
            end
        end
        busy = nb;
    endtask

    task automatic applyStimulus(input bit v, input logic [5:0] rob, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [2:0] size,
                                 input bit cv, input logic [5:0] crob, input bit fl, input bit ack);
        in_valid = v; in_rob = rob; in_addr = addr; in_data = data; in_size = size;
        commit_valid = cv; commit_rob = crob; flush = fl; mem_ack = ack;
        checkModel();
        @(posedge clock);
        modelUpdate();
        @(negedge clock);
    endtask

    task automatic enq(input logic [5:0] rob, input logic [31:0] addr, input logic [31:0] data, input logic [2:0] size);
        applyStimulus(1'b1, rob, addr, data, size, 1'b0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic cmt(input logic [5:0] rob);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 3'd0, 1'b1, rob, 1'b0, 1'b0);
    endtask

    task automatic idle(input bit ack);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 3'd0, 1'b0, 6'd0, 1'b0, ack);
    endtask

    task automatic clearModel();
        q.delete();
        busy = 1'b0;
        ovf  = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        // Reset state
        reset = 1'b0;
        clearModel();
        @(negedge clock);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_mem_be", 32'(mem_be), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Single SW drains with a two-cycle held request
        enq(6'd3, 32'h104, 32'hDEADBEEF, 3'b010);
        cmt(6'd3);
        idle(1'b0);
        checkOutput("sw_req_c1", 32'(mem_req), 32'd1);
        checkOutput("sw_addr", mem_addr, 32'h104);
        checkOutput("sw_be", 32'(mem_be), 32'hF);
        checkOutput("sw_wdata", mem_wdata, 32'hDEADBEEF);
        idle(1'b0);
        checkOutput("sw_req_c2", 32'(mem_req), 32'd1);
        idle(1'b1);
        checkOutput("sw_req_done", 32'(mem_req), 32'd0);
        checkOutput("sw_empty", 32'(empty), 32'd1);

        // SB at byte 3 of its word
        enq(6'd5, 32'h203, 32'h0000005A, 3'b000);
        cmt(6'd5);
        idle(1'b0);
        checkOutput("sb_be", 32'(mem_be), 32'b1000);
        checkOutput("sb_wdata", mem_wdata, 32'h5A5A5A5A);
        checkOutput("sb_addr", mem_addr, 32'h200);
        idle(1'b1);
        idle(1'b0);

        // Fill to capacity, then one extra store is refused
        for (int i = 0; i < DEPTH; i++) enq(6'(i + 1), 32'h400 + 32'(4 * i), 32'(i), 3'b010);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        enq(6'd7, 32'h500, 32'h77, 3'b010);
        checkOutput("full_count", 32'(count), 32'd4);
        checkOutput("full_overflow", 32'(overflow), 32'd1);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 3'd0, 1'b0, 6'd0, 1'b1, 1'b0);
        checkOutput("flush_all_count", 32'(count), 32'd0);

        // Flush keeps only the committed oldest store
        enq(6'd1, 32'h300, 32'h11, 3'b010);
        enq(6'd2, 32'h304, 32'h22, 3'b010);
        enq(6'd3, 32'h308, 32'h33, 3'b010);
        cmt(6'd1);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 3'd0, 1'b0, 6'd0, 1'b1, 1'b0);
        checkOutput("flush_keep_count", 32'(count), 32'd1);
        checkOutput("flush_keep_addr", mem_addr, 32'h300);
        idle(1'b1);
        idle(1'b0);
        checkOutput("flush_keep_empty", 32'(empty), 32'd1);

        // Commit tag equal to the invalid marker never matches; SH in upper half
        enq(INV, 32'h600, 32'h1, 3'b010);
        cmt(INV);
        idle(1'b0);
        checkOutput("inv_rob_no_req", 32'(mem_req), 32'd0);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 3'd0, 1'b0, 6'd0, 1'b1, 1'b0);
        enq(6'd9, 32'h703, 32'hABCD1234, 3'b001);
        cmt(6'd9);
        idle(1'b0);
        checkOutput("sh_be", 32'(mem_be), 32'b1100);
        checkOutput("sh_wdata", mem_wdata, 32'h12341234);
        idle(1'b1);

`ifdef STORE_FWD_EN
        // Forwarding from pending stores
        enq(6'd4, 32'h40, 32'h7, 3'b010);
        ld_addr = 32'h40;
        #1;
        checkOutput("fwd_hit", 32'(ld_hit), 32'd1);
        checkOutput("fwd_data", ld_data, 32'h7);
        enq(6'd5, 32'h41, 32'h9, 3'b000);
        #1;
        checkOutput("fwd_stall", 32'(ld_stall), 32'd1);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 3'd0, 1'b0, 6'd0, 1'b1, 1'b0);
`endif

        // Reset in the middle of a write
        enq(6'd2, 32'h800, 32'h55, 3'b010);
        cmt(6'd2);
        idle(1'b0);
        checkOutput("pre_rst_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_rst_req", 32'(mem_req), 32'd0);
        checkOutput("async_rst_count", 32'(count), 32'd0);
        clearModel();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Randomized traffic against the reference model
        for (int n = 0; n < 700; n++) begin
            bit          v, cv, fl, ack;
            logic [5:0]  rob, crob;
            logic [31:0] addr, data;
            logic [2:0]  size;
            int          r;
            v    = ($urandom_range(0, 99) < 55);
            rob  = ($urandom_range(0, 15) == 0) ? INV : 6'($urandom_range(0, 7));
            addr = $urandom();
            data = $urandom();
            r    = $urandom_range(0, 9);
            size = (r < 3) ? 3'b000 : (r < 6) ? 3'b001 : (r < 9) ? 3'b010 : 3'($urandom_range(3, 7));
            cv   = ($urandom_range(0, 1) == 1);
            crob = ($urandom_range(0, 1) == 1) ? INV : 6'd63;
            foreach (q[i]) begin
                if (!q[i].committed) begin
                    if ($urandom_range(0, 3) != 0) crob = q[i].rob;
                    break;
                end
            end
            fl  = ($urandom_range(0, 24) == 0);
            ack = ($urandom_range(0, 99) < 40);
`ifdef STORE_FWD_EN
            if (q.size() > 0 && $urandom_range(0, 1) == 1)
                ld_addr = q[$urandom_range(0, q.size() - 1)].addr ^ 32'($urandom_range(0, 3));
            else
                ld_addr = $urandom();
`endif
            applyStimulus(v, rob, addr, data, size, cv, crob, fl, ack);
        end
        checkModel();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
